// File: rtl/multiphase_clk_gen.sv
// Multi-phase clock generator: a prescaler ticks a Johnson counter whose
// true/complement bits form NUM_PHASES evenly spaced 50% phases.
module multiphase_clk_gen #(
  parameter int NUM_PHASES = 4,
  parameter int DIV_W      = 8,
  parameter int DIV_RST    = 0,
  parameter int SEL_W      = $clog2(NUM_PHASES)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  cfg_load_i,
  input  logic [DIV_W-1:0]      div_in_i,
  input  logic [SEL_W-1:0]      phase_sel_i,
  output logic [NUM_PHASES-1:0] phase_o,
  output logic                  clk_out_o,
  output logic                  sync_o,
  output logic                  cfg_pending_o
);

  localparam int K = NUM_PHASES / 2;
  localparam logic [K-1:0] Q_LAST = K'(1) << (K - 1);

  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [DIV_W-1:0]      pdiv_q, pdiv_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [SEL_W-1:0]      psel_q, psel_d;
  logic                  pend_q, pend_d;
  logic [K-1:0]          q_q, q_d, q_shift;
  logic [NUM_PHASES-1:0] phase_q, phase_d;
  logic                  clk_out_q, clk_out_d;
  logic                  sync_q, sync_d;
  logic                  tick, wrap;

  generate
    if (K == 1) begin : g_k1
      assign q_shift = ~q_q;
    end else begin : g_kn
      assign q_shift = {q_q[K-2:0], ~q_q[K-1]};
    end
  endgenerate

  always_comb begin
    tick    = en_i && (cnt_q == div_q);
    wrap    = tick && (q_q == Q_LAST);
    cnt_d   = tick ? '0 : (en_i ? cnt_q + DIV_W'(1) : cnt_q);
    q_d     = tick ? q_shift : q_q;
    sync_d  = tick && (q_q == '0);

    div_d   = div_q;
    sel_d   = sel_q;
    pdiv_d  = pdiv_q;
    psel_d  = psel_q;
    pend_d  = pend_q;
    // A load landing on the wrap itself bypasses the pending stage.
    if (wrap) begin
      if (cfg_load_i) begin
        div_d = div_in_i;
        sel_d = phase_sel_i;
      end else if (pend_q) begin
        div_d = pdiv_q;
        sel_d = psel_q;
      end
      pend_d = 1'b0;
    end else if (cfg_load_i) begin
      pdiv_d = div_in_i;
      psel_d = phase_sel_i;
      pend_d = 1'b1;
    end

    phase_d = '0;
    for (int i = 0; i < K; i++) begin
      phase_d[i]     = q_d[i];
      phase_d[i + K] = ~q_d[i];
    end

    // Out-of-range selects match no index and leave clk_out low.
    clk_out_d = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (sel_d == SEL_W'(i)) clk_out_d = phase_d[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      q_q       <= '0;
      div_q     <= DIV_W'(DIV_RST);
      sel_q     <= '0;
      pdiv_q    <= '0;
      psel_q    <= '0;
      pend_q    <= 1'b0;
      phase_q   <= {{K{1'b1}}, {K{1'b0}}};
      clk_out_q <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      div_q     <= div_d;
      sel_q     <= sel_d;
      pdiv_q    <= pdiv_d;
      psel_q    <= psel_d;
      pend_q    <= pend_d;
      phase_q   <= phase_d;
      clk_out_q <= clk_out_d;
      sync_q    <= sync_d;
    end
  end

  assign phase_o       = phase_q;
  assign clk_out_o     = clk_out_q;
  assign sync_o        = sync_q;
  assign cfg_pending_o = pend_q;

endmodule

// File: tb/tb_multiphase_clk_gen.sv
// Directed scoreboard bench: stimulus pushes hand-derived expectations per
// cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_multiphase_clk_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, cfg_load;
  logic [7:0] div_in;
  logic [1:0] phase_sel;
  logic [3:0] phase;
  logic       clk_out, sync, cfg_pending;

  logic       en6 = 1'b1, ld6 = 1'b0;
  logic [7:0] div6 = 8'd0;
  logic [2:0] sel6 = 3'd0;
  logic [5:0] phase6;
  logic       clk_out6, sync6, pend6;

  multiphase_clk_gen #(.NUM_PHASES(4), .DIV_W(8), .DIV_RST(0)) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .cfg_load_i(cfg_load),
    .div_in_i(div_in), .phase_sel_i(phase_sel), .phase_o(phase),
    .clk_out_o(clk_out), .sync_o(sync), .cfg_pending_o(cfg_pending));

  multiphase_clk_gen #(.NUM_PHASES(6), .DIV_W(8), .DIV_RST(0)) dut6 (
    .clk_i(clk), .reset_i(reset), .en_i(en6), .cfg_load_i(ld6),
    .div_in_i(div6), .phase_sel_i(sel6), .phase_o(phase6),
    .clk_out_o(clk_out6), .sync_o(sync6), .cfg_pending_o(pend6));

  // Johnson states, hand-derived: index = ticks since the all-zero state.
  logic [3:0] ph4 [4] = '{4'b1100, 4'b1001, 4'b0011, 4'b0110};
  logic [5:0] ph6 [6] = '{6'b111000, 6'b110001, 6'b100011,
                          6'b000111, 6'b001110, 6'b011100};

  typedef struct {
    logic [3:0] ph;
    logic       co, sy, pd;
    bit         c6;
    logic [5:0] ph6;
    logic       sy6;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk({e.nm, ".phase"},   8'(phase),       8'(e.ph));
      chk({e.nm, ".clk_out"}, 8'(clk_out),     8'(e.co));
      chk({e.nm, ".sync"},    8'(sync),        8'(e.sy));
      chk({e.nm, ".pending"}, 8'(cfg_pending), 8'(e.pd));
      if (e.c6) begin
        chk({e.nm, ".phase6"}, 8'(phase6), 8'(e.ph6));
        chk({e.nm, ".sync6"},  8'(sync6),  8'(e.sy6));
      end
    end
  end

  // Apply one cycle of inputs, then queue the outputs expected after that edge.
  task automatic cyc(input bit rst, input bit e, input bit ld, input int dv,
                     input int sl, input int s, input int sel, input bit sy,
                     input bit pd, input string nm, input bit c6 = 0,
                     input int s6 = 0);
    exp_t x;
    logic [3:0] p;
    reset = rst; en = e; cfg_load = ld;
    div_in = 8'(dv); phase_sel = 2'(sl);
    @(posedge clk);
    p     = ph4[s];
    x.ph  = p;
    x.co  = rst ? 1'b0 : p[sel];
    x.sy  = sy;
    x.pd  = pd;
    x.c6  = c6;
    x.ph6 = ph6[s6];
    x.sy6 = (s6 == 1);
    x.nm  = nm;
    sbq.push_back(x);
    #1;
  endtask

  initial begin
    int s;
    // reset, including reset overriding en and cfg_load
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst", 1, 0);
    cyc(1, 1, 1, 5, 3, 0, 0, 0, 0, "rst_ovr", 1, 0);

    // basic 4-phase and 6-phase sequences at div 0
    for (int n = 1; n <= 12; n++) begin
      s = n % 4;
      cyc(0, 1, 0, 0, 0, s, 0, s == 1, 0, "t1", 1, n % 6);
    end

    // divider change loaded at second clk of a period
    cyc(0, 1, 0, 0, 0, 1, 0, 1, 0, "t2a");
    cyc(0, 1, 1, 2, 0, 2, 0, 0, 1, "t2ld");
    cyc(0, 1, 0, 0, 0, 3, 0, 0, 1, "t2b");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, "t2wrap");
    for (int j = 1; j <= 24; j++) begin
      s = (j / 3) % 4;
      cyc(0, 1, 0, 0, 0, s, 0, (j % 3 == 0) && (s == 1), 0, "t2div");
    end

    // freeze for 5 cycles mid-period
    for (int j = 1; j <= 4; j++) begin
      s = (j / 3) % 4;
      cyc(0, 1, 0, 0, 0, s, 0, (j % 3 == 0) && (s == 1), 0, "t3pre");
    end
    repeat (5) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, "t3frz");
    for (int j = 5; j <= 24; j++) begin
      s = (j / 3) % 4;
      cyc(0, 1, 0, 0, 0, s, 0, (j % 3 == 0) && (s == 1), 0, "t3res");
    end

    // phase select 0 -> 2 with div 1, applied at wrap
    for (int j = 1; j <= 12; j++) begin
      s = (j / 3) % 4;
      cyc(0, 1, j == 1, 1, 2, s, (j == 12) ? 2 : 0,
          (j % 3 == 0) && (s == 1), j < 12, "t4a");
    end
    // cfg_load on the wrap cycle applies directly (div 3, sel 0)
    for (int m = 1; m <= 8; m++) begin
      s = (m / 2) % 4;
      cyc(0, 1, m == 8, 3, 0, s, (m == 8) ? 0 : 2,
          (m % 2 == 0) && (s == 1), 0, (m == 8) ? "t4ldwrap" : "t4b");
    end

    // two loads before wrap: last (div 1) wins
    for (int p = 1; p <= 16; p++) begin
      s = (p / 4) % 4;
      cyc(0, 1, p <= 2, (p == 1) ? 7 : 1, 0, s, 0,
          (p % 4 == 0) && (s == 1), p < 16, "t5lw");
    end
    for (int q = 1; q <= 4; q++) begin
      s = (q / 2) % 4;
      cyc(0, 1, q == 3, 2, 0, s, 0, (q % 2 == 0) && (s == 1), q >= 3, "t5pend");
    end

    // reset mid-period discards pending config, restarts at div 0
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, "t5rst");
    for (int r = 1; r <= 8; r++) begin
      s = r % 4;
      cyc(0, 1, 0, 0, 0, s, 0, s == 1, 0, "t5rel");
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain act=%0d exp=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiphase_clk_gen.md
# multiphase_clk_gen

Parametrised multi-phase clock generator: produces NUM_PHASES equally spaced, 50 %-duty phase outputs from the system clock. The outputs come from a programmable prescaler driving a Johnson counter. This block generalises the fixed four-phase (0/90/180/270) generator. It adds:
- runtime division;
- enable/freeze;
- a phase-aligned sync pulse;
- a selectable single-phase output whose configuration changes are applied only at period boundaries.

## Interface
- NUM_PHASES, 4: number of phase outputs; even, ≥ 2. K = NUM_PHASES/2 is the Johnson counter length.
- DIV_W, 8: width of the divider value.
- DIV_RST, 0: divider value loaded at reset.
- SEL_W, $clog2(NUM_PHASES): width of the phase select.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; low freezes all state.
- cfg_load  in  1  one-cycle strobe that captures div_in and phase_sel.
- div_in  in  DIV_W  ticks occur every div_in+1 clk cycles.
- phase_sel  in  SEL_W  index of the phase routed to clk_out.
- phase  out  NUM_PHASES  phase bus; phase[i] lags phase[0] by i ticks.
- clk_out  out  1  registered copy of phase[sel_q].
- sync  out  1  one-cycle pulse coincident with each phase[0] rising edge.
- cfg_pending  out  1  high while a captured configuration awaits the period boundary.

## Operation
Prescaler:
- cnt (DIV_W bits) produces tick = en && (cnt == div_q).
- On tick, cnt <= 0; else if en, cnt <= cnt+1.

Johnson counter:
- q (K bits) advances on tick only: q <= {q[K-2:0], ~q[K-1]}; for K=1, q <= ~q.
- Sequence is 2K states long; the period is NUM_PHASES ticks.

Phase bus:
- For i < K: phase[i] = q[i] and phase[i+K] = ~q[i].
- All phase bits are driven directly from flops (no combinational logic on outputs).

Boundary (wrap):
- wrap = tick && (q == {1'b1, {K-1{1'b0}}}), i.e. the tick that returns q to all-zero.

Configuration:
- cfg_load captures div_in/phase_sel into pending registers and sets cfg_pending.
- On wrap, pending values move to div_q/sel_q and cfg_pending clears.
- A second cfg_load before wrap overwrites the pending values; last load wins.
- cfg_load in the same cycle as wrap: the new values are applied at that wrap directly, and cfg_pending stays 0.

sync:
- sync <= tick && (q == 0), so sync is high in the same cycle phase[0] goes high.

clk_out:
- Registered from the next-state phase bus indexed by the next-state sel_q, so it stays aligned with phase.
- clk_out changes only on ticks, so the minimum high/low time is one tick. A single stretched or shortened pulse on a phase_sel change is permitted.

phase_sel ≥ NUM_PHASES: clk_out is held at 0.

en low: cnt, q, div_q, sel_q, phase and clk_out all hold; sync = 0. cfg_load is still accepted. Counting resumes exactly where it stopped.

## Timing
Reset values (synchronous; applied at the first rising edge with reset = 1, overriding en and cfg_load):
- cnt = 0, q = 0, div_q = DIV_RST, sel_q = 0;
- phase[K-1:0] = 0, phase[NUM_PHASES-1:K] = all 1;
- clk_out = 0, sync = 0, cfg_pending = 0; pending registers cleared.

Reset asserted mid-period: all of the above take effect at the next edge. Any pending configuration is discarded.

First edge after reset release, with en = 1 and div_q = 0:
- tick; phase[0] rises, phase[K] falls, sync = 1.

Latencies:
- tick period: div_q+1 clk cycles.
- phase[i] rising edge: i ticks after phase[0] rising edge.
- Output period: NUM_PHASES·(div_q+1) clk cycles.
- cfg_load to effect: up to one full output period (applied at the next wrap).
- cfg_pending: rises the cycle after cfg_load; falls the cycle after wrap.

## Test plan
1. NUM_PHASES=4, DIV_RST=0, reset then en=1 -> phase sequence 0b1100, 0b1001, 0b0011, 0b0110, 0b1100, repeating; period 4 clk; sync high every 4th cycle with phase[0]; phase[1..3] lag phase[0] by 1, 2, 3 clk.
2. cfg_load div_in=2 at the second clk of a period -> cfg_pending=1; the current period still completes at 4 clk; subsequent ticks every 3 clk; period 12 clk; cfg_pending clears after wrap.
3. en=0 for 5 cycles mid-period -> phase, clk_out and cnt frozen, sync=0; after en returns, the remaining ticks of the period occur unchanged (period stretched by exactly 5 clk).
4. phase_sel 0→2 via cfg_load, div=1 -> clk_out follows phase[0] until wrap, then follows phase[2]; no clk_out high or low interval shorter than 2 clk.
5. reset pulsed mid-period after div_in=3 was applied and a further cfg_load is pending -> next edge shows all reset values, div_q=DIV_RST, cfg_pending=0, and the first period after release restarts at 4 clk.
6. NUM_PHASES=6, div=0 -> six phases spaced 1 clk, period 6 clk, each phase 3 clk high / 3 clk low; phase[3..5] are the complements of phase[0..2].
